// File: rtl/y86_mem_pkg.sv
// Shared types and address-decode helpers for the Y86 data memory controller.
package y86_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mem_state_e;

  // Instruction codes that touch data memory.
  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  // Helpers operate on a zero-extended address of this width.
  localparam int unsigned MemAddrMaxW = 64;

  // Word index: address with the byte-offset field stripped (lsb = 0 for word addressing).
  function automatic logic [MemAddrMaxW-1:0] mem_word_idx(input logic [MemAddrMaxW-1:0] addr,
                                                           input int unsigned lsb);
    return addr >> lsb;
  endfunction

  // Any index bit at or above idx_w is out of range (no aliasing); optionally the
  // byte-offset field must be zero.
  function automatic logic mem_addr_err(input logic [MemAddrMaxW-1:0] addr,
                                        input int unsigned lsb,
                                        input int unsigned idx_w,
                                        input logic align_chk);
    logic [MemAddrMaxW-1:0] low_mask;
    logic range_err;
    logic align_err;
    low_mask  = (64'd1 << lsb) - 64'd1;
    range_err = ((addr >> lsb) >> idx_w) != 64'd0;
    align_err = align_chk & ((addr & low_mask) != 64'd0);
    return range_err | align_err;
  endfunction

endpackage

// File: rtl/y86_dmem_ctrl_if.sv
// Request/response handshake bundle between the datapath and the data memory controller.
interface y86_dmem_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic              err_sticky;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error, err_sticky
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error, err_sticky
  );
endinterface

// File: rtl/y86_dmem_array.sv
// Single-port synchronous RAM; read-during-write returns the old word.
module y86_dmem_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled cycle; rdata holds its value between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/y86_dmem_ctrl.sv
// Clocked Y86 data memory: handshake FSM, wait-state counter, error decode, sticky error.
module y86_dmem_ctrl
  import y86_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BYTE_ADDR = 1,
  parameter int unsigned ALIGN_CHK = 1,
  parameter int unsigned LATENCY   = 1
) (
  input logic            clk,
  input logic            rst,
  y86_dmem_ctrl_if.slave bus
);

  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam int unsigned ByteLsb = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0;
  localparam logic        AlignEn = (ALIGN_CHK != 0) && (BYTE_ADDR != 0);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rd_ok_q, rd_ok_d;
  logic              sticky_q, sticky_d;

  logic [63:0]       addr_ext;
  logic              accept;
  logic              acc_err;
  logic [IdxW-1:0]   word_idx;
  logic [DATA_W-1:0] arr_rdata;

  assign addr_ext = 64'(bus.req_addr);
  assign acc_err  = mem_addr_err(addr_ext, ByteLsb, IdxW, AlignEn);
  assign word_idx = IdxW'(mem_word_idx(addr_ext, ByteLsb));

  assign bus.req_ready = (state_q == StIdle) & ~rst;
  assign accept        = bus.req_valid & bus.req_ready;

  // Array is touched only on a clean accept, so its read register doubles as the
  // response data holding register.
  y86_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (accept & ~acc_err),
    .we    (bus.req_write),
    .addr  (word_idx),
    .wdata (bus.req_wdata),
    .rdata (arr_rdata)
  );

  // State and response-attribute registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_ok_q  <= rd_ok_d;
      sticky_q <= sticky_d;
    end
  end

  // Next-state: capture access outcome at accept, count wait states, wait for consumer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rd_ok_d  = rd_ok_q;
    sticky_d = sticky_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = acc_err;
          rd_ok_d = ~acc_err & ~bus.req_write;
          if (acc_err) begin
            sticky_d = 1'b1;
          end
          if (LATENCY > 0) begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_error = bus.resp_valid & err_q;
  assign bus.resp_rdata = (bus.resp_valid & rd_ok_q) ? arr_rdata : '0;
  assign bus.err_sticky = sticky_q;

endmodule
